// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle fetch/decode/execute control FSM for the 8-bit
//               accumulator processor. Sequences the program counter, program
//               ROM, instruction register, ACU and R0/R1 write strobes.
//               Provides run / single-step / halt debug control, a ROM
//               wait-state handshake with timeout, and a retired-instruction
//               counter.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               run, step           - continuous run level / single-step pulse
//               halt_req, resume    - debug halt request / leave HALT
//               rom_ack             - ROM data valid this cycle
//               instr_code[5:0]     - opcode from the instruction decoder
//               rom_req, ir_load    - FETCH strobes
//               pc_inc, pc_load     - program counter strobes (EXEC)
//               acu_we, acu_sel_imm - ACU write / immediate source select
//               reg_we              - R0/R1 write (store)
//               busy, halted, fault - registered status
//               state_dbg[2:0]      - IDLE=0 FETCH=1 DECODE=2 EXEC=3 HALT=4
//               instr_cnt[15:0]     - retired instructions (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter logic [5:0]  LD_CODE   = 6'b001010,
  parameter logic [5:0]  ST_CODE   = 6'b001011,
  parameter logic [5:0]  JMPF_CODE = 6'b001100,
  parameter logic [5:0]  JMPB_CODE = 6'b001101,
  parameter logic [5:0]  NOP_CODE  = 6'b111100,
  parameter logic [5:0]  HLT_CODE  = 6'b111111,
  parameter logic [5:0]  ALU_MASK  = 6'b110000,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        rom_ack,
  input  logic [5:0]  instr_code,
  output logic        rom_req,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        acu_we,
  output logic        acu_sel_imm,
  output logic        reg_we,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state_dbg,
  output logic [15:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic        pend_halt_q, pend_halt_d;
  logic        single_q, single_d;
  logic [3:0]  tmo_cnt_q, tmo_cnt_d;
  logic        fault_q, fault_d;
  logic [15:0] instr_cnt_q, instr_cnt_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;

  // The explicit opcodes are checked first; every code with both top bits
  // clear is an ALU operation (LD/ST/JMPF/JMPB also live in that space).
  function automatic logic is_legal(input logic [5:0] c);
    return (c == LD_CODE) || (c == ST_CODE) || (c == JMPF_CODE) ||
           (c == JMPB_CODE) || (c == NOP_CODE) || (c == HLT_CODE) ||
           ((c & ALU_MASK) == 6'b000000);
  endfunction

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pend_halt_d = pend_halt_q;
    single_d    = single_q;
    tmo_cnt_d   = tmo_cnt_q;
    fault_d     = fault_q;
    instr_cnt_d = instr_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (step) begin
          single_d = 1'b1;
          state_d  = S_FETCH;
        end else if (run) begin
          single_d = 1'b0;
          state_d  = S_FETCH;
        end
      end

      S_FETCH: begin
        if (halt_req) pend_halt_d = 1'b1;
        if (rom_ack) begin
          tmo_cnt_d = 4'd0;
          state_d   = S_DECODE;
        end else if (tmo_cnt_q == 4'(TIMEOUT - 1)) begin
          // ROM never answered: give up and park in HALT with a fault
          tmo_cnt_d = 4'd0;
          fault_d   = 1'b1;
          state_d   = S_HALT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 4'd1;
        end
      end

      S_DECODE: begin
        if (halt_req) pend_halt_d = 1'b1;
        op_d = instr_code;
        if (!is_legal(instr_code)) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (op_q != HLT_CODE) instr_cnt_d = instr_cnt_q + 16'd1;
        // a halt request arriving in EXEC itself stops at this boundary
        if (op_q == HLT_CODE || pend_halt_q || halt_req) state_d = S_HALT;
        else if (single_q)                               state_d = S_IDLE;
        else if (run)                                    state_d = S_FETCH;
        else                                             state_d = S_IDLE;
      end

      S_HALT: begin
        if (resume) begin
          fault_d     = 1'b0;
          pend_halt_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d == S_HALT && state_q != S_HALT) pend_halt_d = 1'b0;

    busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
    halted_d = (state_d == S_HALT);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 6'd0;
      pend_halt_q <= 1'b0;
      single_q    <= 1'b0;
      tmo_cnt_q   <= 4'd0;
      fault_q     <= 1'b0;
      instr_cnt_q <= 16'd0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pend_halt_q <= pend_halt_d;
      single_q    <= single_d;
      tmo_cnt_q   <= tmo_cnt_d;
      fault_q     <= fault_d;
      instr_cnt_q <= instr_cnt_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath strobes: decoded from the current state and latched opcode
  // --------------------------------------------------------------------------
  always_comb begin
    rom_req     = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    acu_we      = 1'b0;
    acu_sel_imm = 1'b0;
    reg_we      = 1'b0;
    if (state_q == S_FETCH) begin
      rom_req = 1'b1;
      ir_load = rom_ack;
    end
    if (state_q == S_EXEC) begin
      if (op_q == LD_CODE) begin
        acu_we      = 1'b1;
        acu_sel_imm = 1'b1;
        pc_inc      = 1'b1;
      end else if (op_q == ST_CODE) begin
        reg_we = 1'b1;
        pc_inc = 1'b1;
      end else if (op_q == JMPF_CODE || op_q == JMPB_CODE) begin
        pc_load = 1'b1;
      end else if (op_q == NOP_CODE) begin
        pc_inc = 1'b1;
      end else if ((op_q & ALU_MASK) == 6'b000000) begin
        acu_we = 1'b1;
        pc_inc = 1'b1;
      end
      // HLT: no strobes
    end
  end

  assign busy      = busy_q;
  assign halted    = halted_q;
  assign fault     = fault_q;
  assign state_dbg = state_q;
  assign instr_cnt = instr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer. Random instruction
//               streams and wait states are scored against a behavioural
//               model of opcode classes, cycle counts and end states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, step, halt_req, resume, rom_ack;
  logic [5:0]  instr_code;
  logic        rom_req, ir_load, pc_inc, pc_load, acu_we, acu_sel_imm, reg_we;
  logic        busy, halted, fault;
  logic [2:0]  state_dbg;
  logic [15:0] instr_cnt;

  localparam logic [5:0] LD   = 6'b001010;
  localparam logic [5:0] ST   = 6'b001011;
  localparam logic [5:0] JMPF = 6'b001100;
  localparam logic [5:0] JMPB = 6'b001101;
  localparam logic [5:0] NOP  = 6'b111100;
  localparam logic [5:0] HLT  = 6'b111111;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] model_cnt;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req),
    .resume(resume), .rom_ack(rom_ack), .instr_code(instr_code),
    .rom_req(rom_req), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .acu_we(acu_we), .acu_sel_imm(acu_sel_imm), .reg_we(reg_we),
    .busy(busy), .halted(halted), .fault(fault), .state_dbg(state_dbg),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic bit model_legal(input logic [5:0] c);
    return (c[5:4] == 2'b00) || (c == NOP) || (c == HLT);
  endfunction

  // {acu_we, acu_sel_imm, reg_we, pc_inc, pc_load} expected in EXEC
  function automatic logic [4:0] model_exec(input logic [5:0] c);
    bit jmp, alu;
    if (!model_legal(c) || c == HLT) return 5'b0;
    jmp = (c == JMPF) || (c == JMPB);
    alu = (c[5:4] == 2'b00) && (c != LD) && (c != ST) && !jmp;
    return {(c == LD) || alu, c == LD, c == ST, !jmp, jmp};
  endfunction

  function automatic logic [5:0] rand_legal();
    case ($urandom_range(0, 5))
      0: return LD;
      1: return ST;
      2: return JMPF;
      3: return JMPB;
      4: return NOP;
      default: return {2'b00, 4'($urandom_range(0, 15))};
    endcase
  endfunction

  function automatic logic [5:0] rand_illegal();
    logic [5:0] c;
    do c = 6'($urandom_range(16, 63)); while (c == NOP || c == HLT);
    return c;
  endfunction

  function automatic logic [6:0] strobes();
    return {rom_req, ir_load, acu_we, acu_sel_imm, reg_we, pc_inc, pc_load};
  endfunction

  // ---------------- stimulus helpers (observe only) ----------------
  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; resume = 1'b0;
    rom_ack = 1'b0; instr_code = 6'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_cnt = 16'd0;
  endtask

  task automatic start_run();
    run = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pulse_resume();
    run = 1'b0;
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
  endtask

  // Drives one instruction starting in FETCH. halt_at: 0 none, 1 FETCH,
  // 2 DECODE, 3 EXEC. drop_run lowers run at the start of DECODE.
  task automatic run_one(input logic [5:0] code, input int waits, input int halt_at,
                         input bit drop_run, output int req_n, output int ir_n,
                         output int cyc_n, output logic [6:0] dec_s,
                         output logic [6:0] exe_s, output logic [2:0] end_st);
    req_n = 0; ir_n = 0; cyc_n = 0;
    instr_code = code;
    for (int k = 0; k <= waits; k++) begin
      rom_ack  = (k == waits);
      halt_req = (halt_at == 1) && (k == 0);
      @(negedge clk);
      if (rom_req) req_n++;
      if (ir_load) ir_n++;
      @(posedge clk); #1; cyc_n++;
    end
    rom_ack  = 1'b0;
    halt_req = (halt_at == 2);
    if (drop_run) run = 1'b0;
    @(negedge clk); dec_s = strobes();
    @(posedge clk); #1; cyc_n++;
    halt_req = (halt_at == 3);
    @(negedge clk); exe_s = strobes();
    @(posedge clk); #1; cyc_n++;
    halt_req = 1'b0;
    end_st = state_dbg;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    n_cmp++; if (strobes() !== 7'b0) begin n_bad++; $display("FAIL reset_strobes: got %b want 0", strobes()); end
    n_cmp++; if ({busy, halted, fault} !== 3'b000) begin n_bad++; $display("FAIL reset_status: got %b want 000", {busy, halted, fault}); end
    n_cmp++; if (instr_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0", instr_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_run_program();
    logic [5:0] prog[$];
    int         wq[$];
    int         rq, ir, cy, total;
    logic [6:0] ds, es;
    logic [2:0] st, exp_st;
    bit         last;
    prog = '{LD, ST, 6'b000101, NOP};
    wq   = '{0, 0, 0, 0};
    for (int i = 0; i < 20; i++) begin
      prog.push_back(rand_legal());
      wq.push_back($urandom_range(0, 3));
    end
    total = 0;
    start_run();
    for (int i = 0; i < prog.size(); i++) begin
      last = (i == prog.size() - 1);
      run_one(prog[i], wq[i], 0, last, rq, ir, cy, ds, es, st);
      model_cnt++;
      total += cy;
      exp_st = last ? 3'd0 : 3'd1;
      n_cmp++; if (es !== {2'b00, model_exec(prog[i])}) begin n_bad++; $display("FAIL run_exec[%0d] op %b: got %b want %b", i, prog[i], es, {2'b00, model_exec(prog[i])}); end
      n_cmp++; if (ds !== 7'b0) begin n_bad++; $display("FAIL run_decode_strobes[%0d]: got %b want 0", i, ds); end
      n_cmp++; if ({rq, ir, cy} !== {wq[i] + 1, 1, wq[i] + 3}) begin n_bad++; $display("FAIL run_timing[%0d]: got req=%0d ir=%0d cyc=%0d want %0d/1/%0d", i, rq, ir, cy, wq[i] + 1, wq[i] + 3); end
      n_cmp++; if (st !== exp_st) begin n_bad++; $display("FAIL run_next_state[%0d]: got %0d want %0d", i, st, exp_st); end
      n_cmp++; if (instr_cnt !== model_cnt) begin n_bad++; $display("FAIL run_cnt[%0d]: got %0d want %0d", i, instr_cnt, model_cnt); end
      if (i == 3) begin
        n_cmp++; if (total !== 12) begin n_bad++; $display("FAIL run_first4_cycles: got %0d want 12", total); end
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL run_drop_busy: got %b want 0", busy); end
  endtask

  task automatic test_step();
    int         rq, ir, cy, w, quiet_bad;
    logic [6:0] ds, es;
    logic [2:0] st;
    logic [5:0] c;
    run = 1'b0;
    c = {2'b00, 4'($urandom_range(0, 9))};  // plain ALU ops
    w = $urandom_range(0, 2);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    n_cmp++; if (state_dbg !== 3'd1) begin n_bad++; $display("FAIL step_enter: got %0d want 1", state_dbg); end
    run_one(c, w, 0, 0, rq, ir, cy, ds, es, st);
    model_cnt++;
    n_cmp++; if (es !== {2'b00, model_exec(c)}) begin n_bad++; $display("FAIL step_exec: got %b want %b", es, {2'b00, model_exec(c)}); end
    n_cmp++; if (st !== 3'd0) begin n_bad++; $display("FAIL step_end_state: got %0d want 0", st); end
    n_cmp++; if (instr_cnt !== model_cnt) begin n_bad++; $display("FAIL step_cnt: got %0d want %0d", instr_cnt, model_cnt); end
    quiet_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (strobes() !== 7'b0 || state_dbg !== 3'd0) quiet_bad++;
      @(posedge clk); #1;
    end
    n_cmp++; if (quiet_bad !== 0) begin n_bad++; $display("FAIL step_idle_quiet: got %0d bad cycles want 0", quiet_bad); end
  endtask

  task automatic test_jumps_halt();
    int         rq, ir, cy;
    logic [6:0] ds, es;
    logic [2:0] st;
    logic [5:0] prog[3];
    logic [2:0] exp_st[3];
    prog   = '{JMPF, JMPB, HLT};
    exp_st = '{3'd1, 3'd1, 3'd4};
    start_run();
    for (int i = 0; i < 3; i++) begin
      run_one(prog[i], $urandom_range(0, 2), 0, 0, rq, ir, cy, ds, es, st);
      if (prog[i] != HLT) model_cnt++;
      n_cmp++; if (es !== {2'b00, model_exec(prog[i])}) begin n_bad++; $display("FAIL jump_exec[%0d]: got %b want %b", i, es, {2'b00, model_exec(prog[i])}); end
      n_cmp++; if (st !== exp_st[i]) begin n_bad++; $display("FAIL jump_state[%0d]: got %0d want %0d", i, st, exp_st[i]); end
    end
    n_cmp++; if ({halted, busy} !== 2'b10) begin n_bad++; $display("FAIL hlt_status: got %b want 10", {halted, busy}); end
    n_cmp++; if (instr_cnt !== model_cnt) begin n_bad++; $display("FAIL hlt_cnt: got %0d want %0d", instr_cnt, model_cnt); end
    // run, step and halt_req are ignored while halted
    step = 1'b1; halt_req = 1'b1;
    @(posedge clk); #1;
    step = 1'b0; halt_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (state_dbg !== 3'd4) begin n_bad++; $display("FAIL halt_sticky: got %0d want 4", state_dbg); end
    pulse_resume();
    n_cmp++; if ({state_dbg, halted} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL resume_idle: got st=%0d halted=%b want 0/0", state_dbg, halted); end
  endtask

  task automatic test_wait_timeout();
    int         rq, ir, cy, n, guard;
    logic [6:0] ds, es;
    logic [2:0] st;
    start_run();
    run_one(rand_legal(), 3, 0, 1, rq, ir, cy, ds, es, st);
    model_cnt++;
    n_cmp++; if ({rq, ir} !== {32'd4, 32'd1}) begin n_bad++; $display("FAIL wait3_req_ir: got req=%0d ir=%0d want 4/1", rq, ir); end
    n_cmp++; if (cy !== 6) begin n_bad++; $display("FAIL wait3_cycles: got %0d want 6", cy); end
    // ROM never acknowledges
    rom_ack = 1'b0;
    start_run();
    run = 1'b0;
    n = 0; guard = 0;
    while (state_dbg == 3'd1 && guard < 40) begin
      @(negedge clk);
      if (rom_req) n++;
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++; if (n !== 15) begin n_bad++; $display("FAIL timeout_cycles: got %0d want 15", n); end
    n_cmp++; if ({state_dbg, fault, halted} !== {3'd4, 1'b1, 1'b1}) begin n_bad++; $display("FAIL timeout_halt: got st=%0d fault=%b halted=%b want 4/1/1", state_dbg, fault, halted); end
    n_cmp++; if (instr_cnt !== model_cnt) begin n_bad++; $display("FAIL timeout_cnt: got %0d want %0d", instr_cnt, model_cnt); end
    pulse_resume();
    n_cmp++; if ({state_dbg, fault} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL timeout_resume: got st=%0d fault=%b want 0/0", state_dbg, fault); end
  endtask

  task automatic test_halt_req_illegal();
    int         rq, ir, cy, ha;
    logic [6:0] ds, es;
    logic [2:0] st;
    logic [5:0] c;
    for (int i = 0; i < 7; i++) begin
      ha = (i == 0) ? 2 : $urandom_range(1, 3);
      c  = (i == 0) ? 6'b000101 : rand_legal();
      start_run();
      run_one(c, $urandom_range(0, 2), ha, 0, rq, ir, cy, ds, es, st);
      model_cnt++;
      n_cmp++; if (es !== {2'b00, model_exec(c)}) begin n_bad++; $display("FAIL haltreq_exec[%0d] at %0d: got %b want %b", i, ha, es, {2'b00, model_exec(c)}); end
      n_cmp++; if (st !== 3'd4) begin n_bad++; $display("FAIL haltreq_state[%0d] at %0d: got %0d want 4", i, ha, st); end
      n_cmp++; if (instr_cnt !== model_cnt) begin n_bad++; $display("FAIL haltreq_cnt[%0d]: got %0d want %0d", i, instr_cnt, model_cnt); end
      pulse_resume();
    end
    // halt request straight from IDLE
    halt_req = 1'b1;
    @(posedge clk); #1;
    halt_req = 1'b0;
    n_cmp++; if (state_dbg !== 3'd4) begin n_bad++; $display("FAIL idle_halt: got %0d want 4", state_dbg); end
    pulse_resume();
    // illegal opcodes; the last one is left halted with the fault set
    for (int i = 0; i < 4; i++) begin
      c = (i == 0) ? 6'b100001 : rand_illegal();
      start_run();
      run_one(c, $urandom_range(0, 1), 0, 0, rq, ir, cy, ds, es, st);
      n_cmp++; if (es !== 7'b0) begin n_bad++; $display("FAIL illegal_strobes op %b: got %b want 0", c, es); end
      n_cmp++; if ({st, fault} !== {3'd4, 1'b1}) begin n_bad++; $display("FAIL illegal_fault op %b: got st=%0d fault=%b want 4/1", c, st, fault); end
      n_cmp++; if (instr_cnt !== model_cnt) begin n_bad++; $display("FAIL illegal_cnt: got %0d want %0d", instr_cnt, model_cnt); end
      if (i != 3) pulse_resume();
    end
  endtask

  task automatic test_reset_midway_wrap();
    int         rq, ir, cy;
    logic [6:0] ds, es;
    logic [2:0] st;
    // reset while halted with a fault
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; model_cnt = 16'd0;
    n_cmp++; if ({state_dbg, fault, halted, instr_cnt} !== {3'd0, 1'b0, 1'b0, 16'd0}) begin n_bad++; $display("FAIL rst_from_halt: got st=%0d fault=%b halted=%b cnt=%0d want all 0", state_dbg, fault, halted, instr_cnt); end
    // build up a nonzero count, then reset mid-FETCH
    start_run();
    run_one(NOP, 0, 0, 0, rq, ir, cy, ds, es, st);
    model_cnt++;
    rom_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; model_cnt = 16'd0;
    @(negedge clk);
    n_cmp++; if ({state_dbg, busy, instr_cnt} !== {3'd0, 1'b0, 16'd0}) begin n_bad++; $display("FAIL rst_mid_fetch: got st=%0d busy=%b cnt=%0d want 0/0/0", state_dbg, busy, instr_cnt); end
    n_cmp++; if (strobes() !== 7'b0) begin n_bad++; $display("FAIL rst_mid_fetch_strobes: got %b want 0", strobes()); end
    // reset mid-EXEC: the instruction must not retire
    @(posedge clk); #1;
    start_run();
    instr_code = LD; rom_ack = 1'b1;
    @(posedge clk); #1;
    rom_ack = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (state_dbg !== 3'd3) begin n_bad++; $display("FAIL pre_rst_exec: got %0d want 3", state_dbg); end
    rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({state_dbg, instr_cnt, strobes()} !== {3'd0, 16'd0, 7'b0}) begin n_bad++; $display("FAIL rst_mid_exec: got st=%0d cnt=%0d strobes=%b want 0/0/0", state_dbg, instr_cnt, strobes()); end
    // counter wrap from 0xFFFF
    force dut.instr_cnt_d = 16'hFFFF;
    @(posedge clk); #1;
    release dut.instr_cnt_d;
    model_cnt = 16'hFFFF;
    n_cmp++; if (instr_cnt !== model_cnt) begin n_bad++; $display("FAIL preload_cnt: got %h want %h", instr_cnt, model_cnt); end
    start_run();
    run_one(rand_legal(), 0, 0, 1, rq, ir, cy, ds, es, st);
    model_cnt++;
    n_cmp++; if (instr_cnt !== model_cnt) begin n_bad++; $display("FAIL cnt_wrap: got %h want %h", instr_cnt, model_cnt); end
  endtask

  initial begin
    test_reset();
    test_run_program();
    test_step();
    test_jumps_halt();
    test_wait_timeout();
    test_halt_req_illegal();
    test_reset_midway_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
